// File: rtl/mem_swap_pkg.sv
// rtl/mem_swap_pkg.sv - shared state encoding, default widths and response type for the swap-memory initiator
package mem_swap_pkg;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] addr;
    logic                  last;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/mem_swap_timer.sv
// rtl/mem_swap_timer.sv - loadable up-counter bounding how long a beat waits for the memory return
// expire pulses on the increment that brings the count to TIMEOUT.
module mem_swap_timer
  import mem_swap_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expire = inc && (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_swap_initiator.sv
// rtl/mem_swap_initiator.sv - host command/response front end sequencing single and burst swaps onto memory_16x32
// Define MEM_SWAP_STATS_EN to add the saturating stat_beats / stat_timeouts counters.
module mem_swap_initiator
  import mem_swap_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err
`ifdef MEM_SWAP_STATS_EN
  ,
  output logic [15:0]       stat_beats,
  output logic [7:0]        stat_timeouts
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              err;
  } rsp_reg_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  rsp_reg_t          rsp_q, rsp_d;
  logic              tmr_load, tmr_inc, tmr_expire;
  logic              rsp_hs;

  mem_swap_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );

  // cmd_ready is gated by rst so it reads 0 while reset is held and rises on release.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_q.data;
  assign rsp_addr  = rsp_q.addr;
  assign rsp_last  = rsp_q.last;
  assign rsp_err   = rsp_q.err;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    data_d      = data_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rsp_d       = rsp_q;
    tmr_load    = 1'b0;
    tmr_inc     = 1'b0;
    mem_en_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d = cmd_addr;
          data_d     = cmd_data;
          len_d      = cmd_len;
          beat_d     = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          rsp_d.data = mem_rdata;
          rsp_d.addr = cur_addr_q;
          rsp_d.last = (beat_q == len_q);
          rsp_d.err  = 1'b0;
          state_d    = RESP;
        end else begin
          tmr_inc = 1'b1;
          // A timed-out beat closes the command; later beats are dropped.
          if (tmr_expire) begin
            rsp_d.data = '0;
            rsp_d.addr = cur_addr_q;
            rsp_d.last = 1'b1;
            rsp_d.err  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_hs) begin
          if (rsp_q.last) begin
            state_d = IDLE;
          end else begin
            beat_d     = beat_q + 1'b1;
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory port is registered: load it on the edge that enters ISSUE.
    if (state_d == ISSUE) begin
      mem_en_d    = 1'b1;
      mem_addr_d  = cur_addr_d;
      mem_wdata_d = data_d + DATA_W'(beat_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      data_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rsp_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      data_q      <= data_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rsp_q       <= rsp_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_SWAP_STATS_EN
  logic [15:0] stat_beats_q, stat_beats_d;
  logic [7:0]  stat_timeouts_q, stat_timeouts_d;

  always_comb begin
    stat_beats_d    = stat_beats_q;
    stat_timeouts_d = stat_timeouts_q;
    if (rsp_hs && !rsp_q.err && (stat_beats_q != 16'hFFFF)) begin
      stat_beats_d = stat_beats_q + 16'd1;
    end
    if (tmr_expire && (stat_timeouts_q != 8'hFF)) begin
      stat_timeouts_d = stat_timeouts_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats_q    <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_beats_q    <= stat_beats_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_beats    = stat_beats_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_mem_swap_initiator.sv
// tb/tb_mem_swap_initiator.sv - self-checking bench for mem_swap_initiator with a behavioural 16x32 swap memory
module tb_mem_swap_initiator;
  import mem_swap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_len = '0;
  logic        mem_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_addr;
  logic        rsp_last;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_swap_initiator dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Swap memory: write on enable, return the previous word one cycle later.
  logic [31:0] mem_arr [16] = '{default: 32'h0};
  logic [31:0] mrd = '0;
  logic        mvld = 1'b0;
  bit          stall = 1'b0;

  always @(posedge clk) begin
    mvld <= mem_en;
    if (mem_en) begin
      mrd <= mem_arr[mem_addr];
      mem_arr[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mrd;
  assign mem_valid = mvld && !stall;

  logic [31:0] ref_mem [16];
  rsp_t        rsp_q[$];
  logic [35:0] iss_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  len;
    logic [31:0] exp_data0;
  } vec_t;
  vec_t vecs[6];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    rsp_t        e;
    logic [35:0] m;
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = rsp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
          check("rsp_last", 32'(rsp_last), 32'(e.last));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (mem_en) begin
        if (iss_q.size() == 0) begin
          check("mem_en_unexpected", 32'(mem_en), 32'(0));
        end else begin
          m = iss_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(m[35:32]));
          check("mem_wdata", mem_wdata, m[31:0]);
        end
      end
      if (cmd_ready && rsp_valid) check("ready_valid_excl", 32'(1), 32'(0));
    end
  end

  task automatic send_cmd(input logic [3:0] a, input logic [31:0] d, input logic [3:0] l, input bit to);
    int          n;
    logic [3:0]  ba;
    rsp_t        r;
    n = to ? 1 : int'(l) + 1;
    for (int b = 0; b < n; b++) begin
      ba     = a + 4'(b);
      r.data = to ? 32'h0 : ref_mem[ba];
      r.addr = ba;
      r.last = to ? 1'b1 : (b == int'(l));
      r.err  = to;
      rsp_q.push_back(r);
      iss_q.push_back({ba, d + 32'(b)});
      ref_mem[ba] = d + 32'(b);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mem_en_t1", 32'(mem_en), 32'(1));
    check("mem_addr_t1", 32'(mem_addr), 32'(a));
  endtask

  task automatic do_cmd(input vec_t v);
    int cyc;
    send_cmd(v.addr, v.data, v.len, 1'b0);
    @(posedge clk); #1;
    check("rsp_valid_t2", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    check("rsp_valid_t3", 32'(rsp_valid), 32'(1));
    check("rsp_data_t3", rsp_data, v.exp_data0);
    check("rsp_addr_t3", 32'(rsp_addr), 32'(v.addr));
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("cycles_to_idle", 32'(cyc), 32'(3 * int'(v.len) + 1));
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!(cmd_ready && rsp_q.size() == 0) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("idle_reached", 32'(cyc < 200), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 4'd3,  data: 32'hDEADBEEF, len: 4'd0, exp_data0: 32'h00000000};
    vecs[1] = '{addr: 4'd3,  data: 32'h00000001, len: 4'd0, exp_data0: 32'hDEADBEEF};
    vecs[2] = '{addr: 4'd14, data: 32'h00000100, len: 4'd3, exp_data0: 32'h00000000};
    vecs[3] = '{addr: 4'd15, data: 32'h00000200, len: 4'd1, exp_data0: 32'h00000101};
    vecs[4] = '{addr: 4'd0,  data: 32'hFFFFFFFF, len: 4'd1, exp_data0: 32'h00000201};
    vecs[5] = '{addr: 4'd1,  data: 32'h00000055, len: 4'd0, exp_data0: 32'h00000000};
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_mem_en", 32'(mem_en), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'(1));

    for (int i = 0; i < 6; i++) begin
      do_cmd(vecs[i]);
      wait_idle();
    end

    // Backpressure: hold rsp_ready low across five RESP cycles
    rsp_ready = 1'b0;
    send_cmd(4'd4, 32'h10, 4'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'(1));
      check("hold_rsp_data", rsp_data, 32'h0);
      check("hold_rsp_addr", 32'(rsp_addr), 32'(4));
      check("hold_mem_en", 32'(mem_en), 32'(0));
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Timeout: memory never answers
    stall = 1'b1;
    send_cmd(4'd8, 32'hA5, 4'd2, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check("to_rsp_valid", 32'(rsp_valid), 32'(k == 9));
    end
    check("to_rsp_err", 32'(rsp_err), 32'(1));
    @(posedge clk); #1;
    check("to_cmd_ready", 32'(cmd_ready), 32'(1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("to_no_issue", 32'(mem_en), 32'(0));
    end
    stall = 1'b0;

    // Reset during beat 2 of a four-beat burst
    send_cmd(4'd10, 32'h300, 4'd3, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    rsp_q.delete();
    iss_q.delete();
    ref_mem[13] = 32'h0;
    check("arst_mem_en", 32'(mem_en), 32'(0));
    check("arst_mem_addr", 32'(mem_addr), 32'(0));
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("arst_rsp_data", rsp_data, 32'h0);
    check("arst_rsp_addr", 32'(rsp_addr), 32'(0));
    check("arst_rsp_last", 32'(rsp_last), 32'(0));
    check("arst_cmd_ready", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arel_cmd_ready", 32'(cmd_ready), 32'(1));
    do_cmd('{addr: 4'd12, data: 32'h77, len: 4'd0, exp_data0: 32'h00000302});
    wait_idle();

    check("rsp_q_drained", 32'(rsp_q.size()), 32'(0));
    check("iss_q_drained", 32'(iss_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_swap_initiator.md
Name: mem_swap_initiator

Overview:
- Requester-side front end for the 16x32 single-port swap memory (memory_16x32).
- On each enabled cycle that memory writes `data_in` and, one cycle later, returns the previous word with `valid_out`.
- This block accepts host commands on a ready/valid interface, sequences single or burst accesses onto the memory port, and returns each old word on a ready/valid response interface.
- Adds a response timeout, so a stalled or reset memory cannot hang the host.

Parameters:
- ADDR_W, 4, memory address width; addresses wrap modulo 2**ADDR_W.
- DATA_W, 32, memory word width.
- LEN_W, 4, burst length field width; beats = cmd_len + 1.
- TIMEOUT, 8, maximum WAIT-state cycles for mem_valid before error; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  ADDR_W  start address.
- cmd_data  in  DATA_W  write data for beat 0.
- cmd_len  in  LEN_W  beats minus one.
- mem_en  out  1  memory enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory old-word return.
- mem_valid  in  1  memory return valid.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  DATA_W  old word read from memory.
- rsp_addr  out  ADDR_W  address of this beat.
- rsp_last  out  1  final beat of the command.
- rsp_err  out  1  beat timed out.

Behaviour:
- Reset:
  - Asynchronous and active-high on rst.
  - All outputs are 0 and state is IDLE, except cmd_ready, which is 1 once rst deasserts.
  - Reset mid-burst aborts the burst with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch addr, data and len; clear the beat counter; go to ISSUE.
  - cmd_ready=0 in all other states; commands are never queued.
- ISSUE:
  - Exactly one cycle with mem_en=1, mem_addr=cur_addr, mem_wdata=cmd_data+beat (DATA_W modular add).
  - Clear the timeout counter; go to WAIT.
  - mem_en, mem_addr and mem_wdata are registered outputs, 0 outside ISSUE.
- WAIT:
  - mem_valid=1: capture mem_rdata into rsp_data, cur_addr into rsp_addr, rsp_err=0, rsp_last=(beat==len); go to RESP.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT: rsp_data=0, rsp_err=1, rsp_last=1; go to RESP. The remaining beats are abandoned.
- mem_valid outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - On handshake: if rsp_last, go to IDLE; else beat+1, cur_addr+1 (wraps 15->0), go to ISSUE.
  - rsp_valid drops the cycle after the handshake.
- Latency:
  - Command handshake at edge T: mem_en high in cycle T+1.
  - mem_valid seen in T+2.
  - rsp_valid high from T+3.
  - Back-to-back beats with rsp_ready tied high: one beat per 3 cycles.
- Handshake legality: cmd_ready and rsp_valid are never both 1.

Optional Feature:
- MEM_SWAP_STATS_EN defined:
  - Adds output ports stat_beats (16 bits) and stat_timeouts (8 bits), both reset to 0 and saturating.
  - stat_beats increments on each successful rsp handshake with rsp_err=0.
  - stat_timeouts increments on each WAIT timeout.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package mem_swap_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP).
  - default width constants ADDR_W, DATA_W, LEN_W.
  - TIMEOUT default.
  - response struct typedef (data, addr, last, err).
- One sub-module is natural: mem_swap_timer, a loadable up-counter with a terminal flag at TIMEOUT, used by the WAIT state.

Test Plan:
- Reset, then the memory is cleared. cmd addr=3, data=0xDEADBEEF, len=0 handshake at T -> mem_en=1 at T+1 with addr 3. Response at T+3: rsp_data=0x00000000, rsp_addr=3, rsp_last=1, rsp_err=0.
- Repeat at addr=3 with data=0x00000001 -> rsp_data=0xDEADBEEF.
- Burst addr=14, data=0x100, len=3 -> mem accesses at addresses 14, 15, 0, 1 with wdata 0x100, 0x101, 0x102, 0x103. Four responses; rsp_last only on addr 1.
- Hold rsp_ready low 5 cycles during a burst -> rsp_valid stays high with stable data and addr; no mem_en pulses until the handshake.
- Tie mem_valid=0 -> after 8 WAIT cycles: rsp_valid=1, rsp_err=1, rsp_data=0, rsp_last=1. After the handshake, cmd_ready=1 and the remaining beats are not issued.
- Assert rst during beat 2 of a len=3 burst -> all outputs 0 immediately, no response. cmd_ready=1 after release, and a new command completes normally.
